// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the multi-slave APB bridge: FSM states, the queued
// command record and the slave-select width helper.
`ifndef APB_ARCH_ADDR_W
`define APB_ARCH_ADDR_W 32
`endif
`ifndef APB_ARCH_DATA_W
`define APB_ARCH_DATA_W 32
`endif

package apb_bridge_pkg;

    localparam int ARCH_ADDR_W = `APB_ARCH_ADDR_W;
    localparam int ARCH_DATA_W = `APB_ARCH_DATA_W;
    localparam int ARCH_STRB_W = ARCH_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                   wr;
        logic [ARCH_ADDR_W-1:0] addr;
        logic [ARCH_STRB_W-1:0] strb;
        logic [ARCH_DATA_W-1:0] data;
    } apb_cmd_t;

    // Number of upper address bits used as slave index (none for a single slave).
    function automatic int sel_w(input int num_slv);
        return (num_slv <= 1) ? 0 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// Head entry is read asynchronously so the bridge can pop and launch SETUP on the same edge.
module apb_cmd_fifo
    import apb_bridge_pkg::*;
#(
    parameter type T     = apb_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_count_next;

    assign w_pop  = i_pop && !r_empty;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/apb_multi_bridge.sv
// Host-request to APB4 bridge: queues requests, decodes the slave from the upper
// address bits and returns one response per request (pslverr, decode error, timeout).
module apb_multi_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_SIZE  = DATA_WIDTH / 8,
    parameter int NUM_SLV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trnsfr,
    output logic                          req_ready,
    input  logic                          wr,
    input  logic [ADDR_WIDTH-1:0]         address,
    input  logic [STRB_SIZE-1:0]          strb,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          rsp_valid,
    output logic                          rsp_wr,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic [STRB_SIZE-1:0]          pstrb,
    output logic                          penable,
    output logic [NUM_SLV-1:0]            psel,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLV-1:0]            pready,
    input  logic [NUM_SLV-1:0]            pslverr
);

    localparam int SEL_W = sel_w(NUM_SLV);
    localparam int IDX_W = (SEL_W > 0) ? SEL_W : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB_SIZE-1:0]  strb;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    cmd_t                  w_push_cmd;
    cmd_t                  w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [IDX_W-1:0]      w_head_idx;
    logic                  w_head_ok;
    logic [NUM_SLV-1:0]    w_head_sel;
    logic [DATA_WIDTH-1:0] w_prdata [NUM_SLV];
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_done;
    logic                  w_take;

    apb_state_e            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_tcnt;
    logic                  r_err_wr;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_SIZE-1:0]  r_pstrb;
    logic                  r_penable;
    logic [NUM_SLV-1:0]    r_psel;
    logic                  r_rsp_valid;
    logic                  r_rsp_wr;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_data_out;

    assign w_push_cmd = {wr, address, strb, data_in};

    apb_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (trnsfr && !w_fifo_full),
        .i_data  (w_push_cmd),
        .i_pop   (w_take),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    if (SEL_W == 0) begin : g_single
        assign w_head_idx = '0;
        assign w_head_ok  = 1'b1;
    end else begin : g_decode
        assign w_head_idx = w_head.addr[ADDR_WIDTH-1 -: SEL_W];
        assign w_head_ok  = (32'(w_head_idx) < NUM_SLV);
    end

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign w_head_sel[gi] = (w_head_idx == IDX_W'(gi));
        assign w_prdata[gi]   = prdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_sel_ready = pready[r_idx];
    assign w_sel_err   = pslverr[r_idx];
    assign w_sel_rdata = w_prdata[r_idx];
    assign w_done      = (r_state == ST_ACCESS) && (w_sel_ready || (r_tcnt == TCNT_LAST));
    // The head is taken whenever the FSM is (or is about to be) free for a new command.
    assign w_take      = !w_fifo_empty &&
                         ((r_state == ST_IDLE) || (r_state == ST_ERR) || w_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_err_wr    <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_penable   <= 1'b0;
            r_psel      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: ;
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_tcnt    <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!w_done) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end else begin
                        // A missing pready at the last count is reported like a slave error.
                        r_rsp_valid <= 1'b1;
                        r_rsp_wr    <= r_pwrite;
                        r_rsp_err   <= !w_sel_ready || w_sel_err;
                        r_data_out  <= (w_sel_ready && !w_sel_err && !r_pwrite) ? w_sel_rdata : '0;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_wr    <= r_err_wr;
                    r_rsp_err   <= 1'b1;
                    r_data_out  <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_take) begin
                r_penable <= 1'b0;
                if (w_head_ok) begin
                    r_state  <= ST_SETUP;
                    r_idx    <= w_head_idx;
                    r_psel   <= w_head_sel;
                    r_paddr  <= w_head.addr;
                    r_pwrite <= w_head.wr;
                    r_pwdata <= w_head.wr ? w_head.data : '0;
                    r_pstrb  <= w_head.wr ? w_head.strb : '0;
                end else begin
                    r_state  <= ST_ERR;
                    r_err_wr <= w_head.wr;
                    r_psel   <= '0;
                end
            end
        end
    end

    assign req_ready = !w_fifo_full;
    assign rsp_valid = r_rsp_valid;
    assign rsp_wr    = r_rsp_wr;
    assign rsp_err   = r_rsp_err;
    assign data_out  = r_data_out;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign penable   = r_penable;
    assign psel      = r_psel;

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Randomised bench for apb_multi_bridge (3 slaves so index 3 decodes as an error),
// with per-slave APB responders and a rule-level response model.
module tb_apb_multi_bridge;

    localparam int NSLV = 3;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trnsfr = 1'b0;
    logic        req_ready;
    logic        wr = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  strb = '0;
    logic [31:0] data_in = '0;
    logic        rsp_valid, rsp_wr, rsp_err;
    logic [31:0] data_out;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        penable;
    logic [2:0]  psel;
    logic [95:0] prdata;
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    apb_multi_bridge #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .STRB_SIZE (4),
        .NUM_SLV (NSLV), .FIFO_DEPTH (4), .TIMEOUT (TMO)
    ) dut (
        .clk (clk), .rst (rst), .trnsfr (trnsfr), .req_ready (req_ready),
        .wr (wr), .address (address), .strb (strb), .data_in (data_in),
        .rsp_valid (rsp_valid), .rsp_wr (rsp_wr), .rsp_err (rsp_err), .data_out (data_out),
        .paddr (paddr), .pwrite (pwrite), .pwdata (pwdata), .pstrb (pstrb),
        .penable (penable), .psel (psel), .prdata (prdata), .pready (pready), .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit wr; logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } req_t;
    typedef struct { bit wr; bit err; logic [31:0] data; } rsp_t;
    typedef struct { int idx; logic [31:0] addr; bit wr; logic [31:0] wdata; logic [3:0] strb; } apb_t;

    int          checks = 0;
    int          errors = 0;
    int          wait_cfg [NSLV];
    bit          err_cfg  [NSLV];
    logic [31:0] rdata_cfg[NSLV];
    req_t        req_q[$];
    rsp_t        exp_rsp_q[$];
    apb_t        exp_apb_q[$];
    int          rsp_times[$];
    int          accept_times[$];
    int          stall_accepts;
    bit          gap_en = 0;
    bit          last_err;
    logic [31:0] last_data;

    // Slave responders: pready rises on the ACCESS cycle numbered wait_cfg (0 = first).
    initial begin
        int acc;
        acc = 0; pready = '0; pslverr = '0; prdata = '0;
        forever begin
            @(posedge clk); #1;
            pready = '0; pslverr = '0;
            for (int i = 0; i < NSLV; i++) prdata[i*32 +: 32] = rdata_cfg[i];
            if (penable) begin
                for (int i = 0; i < NSLV; i++)
                    if (psel[i] && acc == wait_cfg[i]) begin
                        pready[i]  = 1'b1;
                        pslverr[i] = err_cfg[i];
                    end
                acc++;
            end else acc = 0;
        end
    end

    function automatic rsp_t model_rsp(req_t r);
        int   idx = int'(r.addr[31:30]);
        rsp_t o;
        o.wr = r.wr; o.err = 1'b0; o.data = '0;
        if (idx >= NSLV || wait_cfg[idx] >= TMO || err_cfg[idx]) o.err = 1'b1;
        else if (!r.wr) o.data = rdata_cfg[idx];
        return o;
    endfunction

    task automatic set_cfg(int s, int w, bit e, logic [31:0] d);
        wait_cfg[s] = w; err_cfg[s] = e; rdata_cfg[s] = d;
    endtask

    function automatic req_t mk_req(bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
        req_t r;
        r.wr = w; r.addr = a; r.strb = s; r.data = d;
        return r;
    endfunction

    task automatic drive_reqs();
        int   n_acc;
        int   idx;
        req_t r;
        apb_t a;
        n_acc = 0; stall_accepts = -1;
        while (req_q.size() > 0) begin
            @(negedge clk);
            if (gap_en && $urandom_range(0, 3) == 0) begin
                trnsfr = 1'b0;
                continue;
            end
            r = req_q[0];
            trnsfr = 1'b1; wr = r.wr; address = r.addr; strb = r.strb; data_in = r.data;
            if (req_ready) begin
                exp_rsp_q.push_back(model_rsp(r));
                idx = int'(r.addr[31:30]);
                if (idx < NSLV) begin
                    a.idx = idx; a.addr = r.addr; a.wr = r.wr;
                    a.wdata = r.wr ? r.data : 32'h0;
                    a.strb  = r.wr ? r.strb : 4'h0;
                    exp_apb_q.push_back(a);
                end
                accept_times.push_back(cyc + 1);
                void'(req_q.pop_front());
                n_acc++;
            end else if (stall_accepts < 0) stall_accepts = n_acc;
        end
        @(negedge clk);
        trnsfr = 1'b0;
    endtask

    task automatic collect(int n, int budget);
        int          got;
        int          left;
        apb_t        a;
        rsp_t        e;
        logic [2:0]  es;
        logic [31:0] setup_addr;
        got = 0; left = budget; setup_addr = '0;
        while (got < n && left > 0) begin
            @(negedge clk);
            left--;
            if (psel !== 3'b000 && penable === 1'b0) begin
                checks++;
                if (exp_apb_q.size() == 0) begin
                    errors++;
                    $display("FAIL apb_unexpected_setup: psel=%b paddr=%h required no transfer", psel, paddr);
                end else begin
                    a = exp_apb_q.pop_front();
                    es = '0; es[a.idx] = 1'b1;
                    setup_addr = a.addr;
                    if ({psel, paddr, pwrite, pwdata, pstrb} !== {es, a.addr, a.wr, a.wdata, a.strb}) begin
                        errors++;
                        $display("FAIL apb_setup: got psel=%b addr=%h wr=%b wdata=%h strb=%h required psel=%b addr=%h wr=%b wdata=%h strb=%h",
                                 psel, paddr, pwrite, pwdata, pstrb, es, a.addr, a.wr, a.wdata, a.strb);
                    end
                end
            end else if (penable === 1'b1) begin
                checks++;
                if (paddr !== setup_addr) begin
                    errors++;
                    $display("FAIL apb_addr_stable: got %h required %h", paddr, setup_addr);
                end
            end
            if (rsp_valid === 1'b1) begin
                got++;
                rsp_times.push_back(cyc);
                last_err = rsp_err; last_data = data_out;
                checks++;
                if (exp_rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: wr=%b err=%b data=%h required none", rsp_wr, rsp_err, data_out);
                end else begin
                    e = exp_rsp_q.pop_front();
                    $display("rsp %0d @%0d wr=%b err=%b data=%h", got, cyc, rsp_wr, rsp_err, data_out);
                    if ({rsp_wr, rsp_err, data_out} !== {e.wr, e.err, e.data}) begin
                        errors++;
                        $display("FAIL rsp_content: got wr=%b err=%b data=%h required wr=%b err=%b data=%h",
                                 rsp_wr, rsp_err, data_out, e.wr, e.err, e.data);
                    end
                end
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL rsp_count: got %0d responses required %0d", got, n);
        end
    endtask

    task automatic run_batch(int n, int budget);
        rsp_times.delete(); accept_times.delete();
        fork
            drive_reqs();
            collect(n, budget);
        join
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        checks++;
        if ({psel, penable, rsp_valid, rsp_wr, rsp_err} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {psel, penable, rsp_valid, rsp_wr, rsp_err});
        end
        checks++;
        if ({data_out, paddr, pwrite, pwdata, pstrb} !== 101'b0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {data_out, paddr, pwrite, pwdata, pstrb});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        set_cfg(0, 0, 0, 32'h1111_0000);
        @(negedge clk);
        trnsfr = 1; wr = 1; address = 32'h0000_00F0; strb = 4'hF; data_in = 32'h000A_3210;
        @(negedge clk); trnsfr = 0;
        checks++;
        if (psel !== 3'b000) begin errors++; $display("FAIL wr_e0_psel: got %b required 000", psel); end
        @(negedge clk);
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb} !== {3'b001, 1'b0, 32'h0000_00F0, 1'b1, 32'h000A_3210, 4'hF}) begin
            errors++; $display("FAIL wr_setup: got psel=%b en=%b addr=%h wr=%b data=%h strb=%h required 001 0 000000f0 1 000a3210 f",
                               psel, penable, paddr, pwrite, pwdata, pstrb);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable, rsp_valid} !== 5'b00110) begin
            errors++; $display("FAIL wr_access: got psel/en/rsp=%b required 00110", {psel, penable, rsp_valid});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_wr, rsp_err, data_out, psel, penable} !== {3'b110, 32'h0, 4'b0}) begin
            errors++; $display("FAIL wr_rsp: got v=%b wr=%b err=%b data=%h psel=%b en=%b required 1 1 0 0 000 0",
                               rsp_valid, rsp_wr, rsp_err, data_out, psel, penable);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b required 0", rsp_valid); end
    endtask

    task automatic test_read_wait();
        int t0;
        bit got;
        set_cfg(1, 2, 0, 32'hC0D9_42F0);
        @(negedge clk);
        trnsfr = 1; wr = 0; address = 32'h4000_00B0; strb = 4'hF; data_in = 32'hDEAD_BEEF;
        t0 = cyc + 1; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); trnsfr = 0;
            if (psel !== 3'b000 && penable === 1'b0) begin
                checks++;
                if ({psel, pstrb, pwdata, pwrite} !== {3'b010, 4'h0, 32'h0, 1'b0}) begin
                    errors++; $display("FAIL rd_setup: got psel=%b strb=%h wdata=%h wr=%b required 010 0 0 0", psel, pstrb, pwdata, pwrite);
                end
            end
            if (rsp_valid === 1'b1) begin
                got = 1;
                checks++;
                if (cyc - t0 != 5) begin errors++; $display("FAIL rd_latency: got %0d required 5", cyc - t0); end
                checks++;
                if ({rsp_wr, rsp_err, data_out} !== {2'b00, 32'hC0D9_42F0}) begin
                    errors++; $display("FAIL rd_rsp: got wr=%b err=%b data=%h required 0 0 c0d942f0", rsp_wr, rsp_err, data_out);
                end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rd_timeout: got no response required one"); end
    endtask

    task automatic test_back_to_back();
        set_cfg(0, 10, 0, 32'h0);
        for (int i = 0; i < 6; i++) req_q.push_back(mk_req(1, 32'h0000_0100 + 32'(i * 4), 4'(i + 1), $urandom));
        run_batch(6, 300);
        checks++;
        if (stall_accepts != 5) begin errors++; $display("FAIL b2b_stall: got %0d accepts before stall required 5", stall_accepts); end
        checks++;
        if (rsp_times.size() != 6 || rsp_times[0] - accept_times[0] != 3 + 10) begin
            errors++; $display("FAIL b2b_first_latency: got %0d required 13",
                               (rsp_times.size() > 0) ? rsp_times[0] - accept_times[0] : -1);
        end
        for (int i = 1; i < rsp_times.size(); i++) begin
            checks++;
            if (rsp_times[i] - rsp_times[i-1] != 2 + 10) begin
                errors++; $display("FAIL b2b_spacing: got %0d required 12", rsp_times[i] - rsp_times[i-1]);
            end
        end
    endtask

    task automatic test_decode_err();
        int t0;
        int bad;
        bit got;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            trnsfr = 1; wr = (k == 0); address = 32'hC000_0000; strb = 4'hF; data_in = 32'h1234_5678;
            t0 = cyc + 1; got = 0; bad = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk); trnsfr = 0;
                if (psel !== 3'b000 || penable !== 1'b0) bad++;
                if (rsp_valid === 1'b1) begin
                    got = 1;
                    checks++;
                    if ({cyc - t0 == 2, rsp_wr, rsp_err, data_out} !== {1'b1, k == 0, 1'b1, 32'h0}) begin
                        errors++; $display("FAIL dec_rsp: got lat=%0d wr=%b err=%b data=%h required 2 %b 1 0",
                                           cyc - t0, rsp_wr, rsp_err, data_out, k == 0);
                    end
                end
            end
            checks++;
            if (!got || bad != 0) begin errors++; $display("FAIL dec_bus: got resp=%b apb_cycles=%0d required 1 0", got, bad); end
        end
    endtask

    task automatic test_timeout();
        int pen;
        pen = 0;
        set_cfg(2, 1000, 0, 32'h5A5A_5A5A);
        set_cfg(0, 1, 0, 32'h0BAD_F00D);
        req_q.push_back(mk_req(1, 32'h8000_0010, 4'h3, 32'hFEED_0001));
        req_q.push_back(mk_req(0, 32'h0000_0020, 4'hF, 32'h0));
        rsp_times.delete(); accept_times.delete();
        fork
            drive_reqs();
            collect(2, 100);
            repeat (60) begin @(negedge clk); if (penable === 1'b1 && psel[2] === 1'b1) pen++; end
        join
        checks++;
        if (pen != TMO) begin errors++; $display("FAIL tmo_penable_cycles: got %0d required %0d", pen, TMO); end
        checks++;
        if (last_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL tmo_next_read: got %h required 0badf00d", last_data); end
    endtask

    task automatic test_pslverr();
        set_cfg(1, 1, 1, 32'h7777_8888);
        req_q.push_back(mk_req(0, 32'h4000_0004, 4'hF, 32'h0));
        run_batch(1, 40);
        checks++;
        if ({last_err, last_data} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL slverr_read: got err=%b data=%h required 1 0", last_err, last_data);
        end
    endtask

    task automatic test_random();
        req_t r;
        gap_en = 1;
        for (int round = 0; round < 4; round++) begin
            for (int s = 0; s < NSLV; s++)
                set_cfg(s, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
            for (int i = 0; i < 15; i++) begin
                r.wr = $urandom_range(0, 1) == 1; r.addr = $urandom; r.strb = 4'($urandom); r.data = $urandom;
                r.addr[31:30] = 2'($urandom_range(0, 3));
                req_q.push_back(r);
            end
            run_batch(15, 2000);
        end
        gap_en = 0;
    endtask

    task automatic test_reset_mid();
        int bad;
        set_cfg(0, 1000, 0, 32'h0);
        for (int i = 0; i < 3; i++) req_q.push_back(mk_req(1, 32'h0000_0040 + 32'(i), 4'hF, $urandom));
        drive_reqs();
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 4'b0011) begin errors++; $display("FAIL rstmid_pre: got psel/en=%b required 0011", {psel, penable}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({psel, penable, req_ready} !== 5'b00001) begin
            errors++; $display("FAIL rstmid_after: got psel/en/ready=%b required 00001", {psel, penable, req_ready});
        end
        exp_rsp_q.delete(); exp_apb_q.delete();
        bad = 0;
        repeat (40) begin @(negedge clk); if (rsp_valid !== 1'b0 || psel !== 3'b000) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles required 0", bad); end
        set_cfg(0, 0, 0, 32'hABCD_0123);
        req_q.push_back(mk_req(0, 32'h0000_0008, 4'hF, 32'h0));
        run_batch(1, 40);
    endtask

    initial begin
        for (int s = 0; s < NSLV; s++) set_cfg(s, 0, 0, 32'h0);
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_decode_err();
        test_timeout();
        test_pslverr();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
